// File: rtl/byte_ser_if.sv
// byte_ser_if: parallel-side handshake and serial-side status of the byte serializer
interface byte_ser_if #(parameter int WIDTH = 8);
   logic [WIDTH-1:0] din;
   logic             din_valid;
   logic             din_ready;
   logic             ser_out;
   logic             busy;
   logic             done;
   modport master (output din, din_valid, input din_ready, ser_out, busy, done);
   modport slave (input din, din_valid, output din_ready, ser_out, busy, done);
endinterface

// File: rtl/byte_ser.sv
// byte_ser: framed serializer (start bit, WIDTH data bits LSB first, stop bit), DIV clocks per bit
module byte_ser #(
   parameter int WIDTH = 8,
   parameter int DIV   = 4
) (
   input logic       clk,
   input logic       rst,
   byte_ser_if.slave bus
);
   localparam int PW = DIV > 1 ? $clog2(DIV) : 1;
   localparam int IW = WIDTH > 1 ? $clog2(WIDTH) : 1;
   typedef enum logic [1:0] {IDLE, START, DATA, STOP} state_t;
   state_t           state;
   logic [WIDTH-1:0] shreg;
   logic [WIDTH-1:0] sh_nx;
   logic [PW-1:0]    pcnt;
   logic [IW-1:0]    idx;
   logic             last;
   assign sh_nx = shreg >> 1;
   assign last = pcnt == PW'(DIV - 1);
   assign bus.din_ready = (state == IDLE) & ~rst;
   // Outputs are set together with the state they belong to, so they stay registered and glitch-free
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         state       <= IDLE;
         shreg       <= '0;
         pcnt        <= '0;
         idx         <= '0;
         bus.ser_out <= 1'b1;
         bus.busy    <= 1'b0;
         bus.done    <= 1'b0;
      end else begin
         bus.done <= 1'b0;
         pcnt     <= last ? '0 : pcnt + 1'b1;
         case (state)
            IDLE: begin
               pcnt <= '0;
               if (bus.din_valid) begin
                  shreg       <= bus.din;
                  idx         <= '0;
                  state       <= START;
                  bus.ser_out <= 1'b0;
                  bus.busy    <= 1'b1;
               end
            end
            START: if (last) begin
               state       <= DATA;
               bus.ser_out <= shreg[0];
            end
            DATA: if (last) begin
               shreg <= sh_nx;
               idx   <= idx + 1'b1;
               if (idx == IW'(WIDTH - 1)) begin
                  state       <= STOP;
                  bus.ser_out <= 1'b1;
               end else
                  bus.ser_out <= sh_nx[0];
            end
            STOP: if (last) begin
               state    <= IDLE;
               bus.busy <= 1'b0;
               bus.done <= 1'b1;
            end
         endcase
      end
   end
endmodule
